// File: rtl/ff_pkg.sv
// rtl/ff_pkg.sv - shared state encoding and edge-select constants for the RS/JK flip-flop bank
package ff_pkg;

   typedef enum logic [1:0] {
      FF_Q0   = 2'd0,
      FF_Q1   = 2'd1,
      FF_BOTH = 2'd2
   } ff_state_e;

   localparam int EDGE_FALL = 0;
   localparam int EDGE_RISE = 1;

   // JK action on an accepted clock edge; only ever called from Q0/Q1
   function automatic ff_state_e jk_next(input ff_state_e cur, input logic j, input logic k);
      ff_state_e nxt;
      nxt = cur;
      if (j && k) begin
         nxt = (cur == FF_Q1) ? FF_Q0 : FF_Q1;
      end else if (j) begin
         nxt = FF_Q1;
      end else if (k) begin
         nxt = FF_Q0;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/rsjk_ff_cell.sv
// rtl/rsjk_ff_cell.sv - one channel: NOR RS latch, edge-selectable JK flip-flop and active-low clear
module rsjk_ff_cell
   import ff_pkg::*;
#(
   parameter int CLK_EDGE = EDGE_FALL,
   parameter bit RESET_Q  = 1'b0,
   parameter bit RACE_Q   = 1'b0
) (
   input  logic clk_drv,
   input  logic rst_n,
   input  logic clk,
   input  logic j,
   input  logic k,
   input  logic s,
   input  logic r,
   input  logic clr_n,
   output logic q,
   output logic q_n
);

   localparam ff_state_e RESET_STATE = RESET_Q ? FF_Q1 : FF_Q0;
   localparam ff_state_e RACE_STATE  = RACE_Q  ? FF_Q1 : FF_Q0;

   ff_state_e state;
   ff_state_e state_nxt;
   logic      prev_clk;
   logic      edge_act;

   always_comb begin
      state_nxt = state;
      edge_act  = (CLK_EDGE == EDGE_RISE) ? (~prev_clk & clk) : (prev_clk & ~clk);

      if (!clr_n) begin
         state_nxt = FF_Q0;
      end else if (s && r) begin
         state_nxt = FF_BOTH;
      end else if (state == FF_BOTH) begin
         // release cycle: the race outcome wins and any coincident edge is dropped
         if (s) begin
            state_nxt = FF_Q1;
         end else if (r) begin
            state_nxt = FF_Q0;
         end else begin
            state_nxt = RACE_STATE;
         end
      end else if (s) begin
         state_nxt = FF_Q1;
      end else if (r) begin
         state_nxt = FF_Q0;
      end else if (edge_act) begin
         state_nxt = jk_next(state, j, k);
      end
   end

   // prev_clk tracks CLK unconditionally, so masked edges are lost rather than deferred
   always_ff @(posedge clk_drv) begin
      if (!rst_n) begin
         state    <= RESET_STATE;
         prev_clk <= clk;
         q        <= RESET_Q;
         q_n      <= ~RESET_Q;
      end else begin
         state    <= state_nxt;
         prev_clk <= clk;
         q        <= (state_nxt == FF_Q1);
         q_n      <= (state_nxt == FF_Q0);
      end
   end

endmodule

// File: rtl/rsjk_ff_bank.sv
// rtl/rsjk_ff_bank.sv - bank of independent RS/JK flip-flop channels emulated on the oversampling clock
module rsjk_ff_bank
   import ff_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int CLK_EDGE = EDGE_FALL,
   parameter bit RESET_Q  = 1'b0,
   parameter bit RACE_Q   = 1'b0
) (
   input  logic                CLK_DRV,
   input  logic                RST_N,
   input  logic [CHANNELS-1:0] CLK,
   input  logic [CHANNELS-1:0] J,
   input  logic [CHANNELS-1:0] K,
   input  logic [CHANNELS-1:0] S,
   input  logic [CHANNELS-1:0] R,
   input  logic [CHANNELS-1:0] CLR_N,
   output logic [CHANNELS-1:0] Q,
   output logic [CHANNELS-1:0] Q_N
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      rsjk_ff_cell #(
         .CLK_EDGE (CLK_EDGE),
         .RESET_Q  (RESET_Q),
         .RACE_Q   (RACE_Q)
      ) u_cell (
         .clk_drv (CLK_DRV),
         .rst_n   (RST_N),
         .clk     (CLK[i]),
         .j       (J[i]),
         .k       (K[i]),
         .s       (S[i]),
         .r       (R[i]),
         .clr_n   (CLR_N[i]),
         .q       (Q[i]),
         .q_n     (Q_N[i])
      );
   end

endmodule

// File: tb/tb_rsjk_ff_bank.sv
// tb/tb_rsjk_ff_bank.sv - self-checking bench: falling-edge and rising-edge banks against a reference model
module tb_rsjk_ff_bank;

   logic       clk_drv = 1'b0;
   logic       rst_n;
   logic [3:0] clk, j, k, s, r, clr_n;
   logic [3:0] q_f, qn_f, q_r, qn_r;

   int n_pass  = 0;
   int n_total = 0;

   // index 0: falling edge, RESET_Q=0, RACE_Q=1; index 1: rising edge, RESET_Q=1, RACE_Q=0
   logic [3:0] mq [2];
   logic [3:0] mqn [2];
   logic [3:0] mprev [2];
   logic       nq, nqn;
   logic       exp_t;

   always #5 clk_drv = ~clk_drv;

   rsjk_ff_bank #(.CHANNELS(4), .CLK_EDGE(0), .RESET_Q(1'b0), .RACE_Q(1'b1)) dut_f (
      .CLK_DRV (clk_drv), .RST_N (rst_n), .CLK (clk), .J (j), .K (k),
      .S (s), .R (r), .CLR_N (clr_n), .Q (q_f), .Q_N (qn_f)
   );

   rsjk_ff_bank #(.CHANNELS(4), .CLK_EDGE(1), .RESET_Q(1'b1), .RACE_Q(1'b0)) dut_r (
      .CLK_DRV (clk_drv), .RST_N (rst_n), .CLK (clk), .J (j), .K (k),
      .S (s), .R (r), .CLR_N (clr_n), .Q (q_r), .Q_N (qn_r)
   );

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 4; c++) begin
            logic cq, cqn, act;
            cq  = mq[d][c];
            cqn = mqn[d][c];
            act = (d == 1) ? (!mprev[d][c] && clk[c]) : (mprev[d][c] && !clk[c]);
            if (!rst_n) begin
               cq = (d == 1); cqn = (d != 1);
            end else if (!clr_n[c]) begin
               cq = 1'b0; cqn = 1'b1;
            end else if (s[c] && r[c]) begin
               cq = 1'b0; cqn = 1'b0;
            end else if (!cq && !cqn) begin
               if (s[c])      begin cq = 1'b1; cqn = 1'b0; end
               else if (r[c]) begin cq = 1'b0; cqn = 1'b1; end
               else           begin cq = (d == 0); cqn = (d != 0); end
            end else if (s[c]) begin
               cq = 1'b1; cqn = 1'b0;
            end else if (r[c]) begin
               cq = 1'b0; cqn = 1'b1;
            end else if (act) begin
               if (j[c] && k[c]) {cq, cqn} = {cqn, cq};
               else if (j[c])    begin cq = 1'b1; cqn = 1'b0; end
               else if (k[c])    begin cq = 1'b0; cqn = 1'b1; end
            end
            mq[d][c]    = cq;
            mqn[d][c]   = cqn;
            mprev[d][c] = clk[c];
         end
      end
   endtask

   // cross-coupled NOR pair settled by iteration; simultaneous release from 0/0 resolves to 1 (falling bank race value)
   task automatic nor_step(input logic sb, input logic rb);
      logic a, b;
      if (sb && rb) begin
         nq = 1'b0; nqn = 1'b0;
      end else if (!sb && !rb && !nq && !nqn) begin
         nq = 1'b1; nqn = 1'b0;
      end else begin
         for (int it = 0; it < 4; it++) begin
            a = ~(rb | nqn);
            b = ~(sb | a);
            nq = a; nqn = b;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_drv);
      model_step();
      #1;
      if (rst_n !== 1'bx) begin
         check("model_f_q",  q_f,  mq[0]);
         check("model_f_qn", qn_f, mqn[0]);
         check("model_r_q",  q_r,  mq[1]);
         check("model_r_qn", qn_r, mqn[1]);
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         mq[d] = '0; mqn[d] = '0; mprev[d] = '0;
      end
      rst_n = 1'b0; clk = '0; j = '0; k = '0; s = '0; r = '0; clr_n = 4'hF;

      // 1: RS sweep on channel 0
      tick(); tick();
      check("rst_q", q_f, 4'h0);
      check("rst_qn", qn_f, 4'hF);
      check("rst_q_rise_bank", q_r, 4'hF);
      nq = 1'b0; nqn = 1'b1;
      rst_n = 1'b1;
      s = 4'b0001; tick(); nor_step(1'b1, 1'b0);
      check("rs_set_q", q_f, 4'h1);
      check("rs_set_qn", qn_f, 4'hE);
      check1("nor_set_q", q_f[0], nq);
      check1("nor_set_qn", qn_f[0], nqn);
      s = 4'b0000;
      for (int i = 0; i < 2; i++) begin
         tick(); nor_step(1'b0, 1'b0);
         check("rs_hold_q", q_f, 4'h1);
         check1("nor_hold_q", q_f[0], nq);
      end
      r = 4'b0001; tick(); nor_step(1'b0, 1'b1);
      check("rs_reset_q", q_f, 4'h0);
      check("rs_reset_qn", qn_f, 4'hF);
      check1("nor_reset_qn", qn_f[0], nqn);
      r = 4'b0000; tick();

      // 2: JK toggle on falling edges of CLK[0]
      j = 4'hF; k = 4'hF;
      exp_t = 1'b0;
      for (int i = 0; i < 3; i++) begin
         clk[0] = 1'b1;
         repeat (4) tick();
         check1("jk_rise_no_change", q_f[0], exp_t);
         clk[0] = 1'b0;
         exp_t = ~exp_t;
         tick();
         check1("jk_fall_toggle", q_f[0], exp_t);
         check("jk_static_ch", {1'b0, q_f[3:1]}, 4'h0);
         repeat (3) tick();
      end
      j = '0; k = '0;

      // 3: BOTH state and release races on channel 1
      s[1] = 1'b1; r[1] = 1'b1; tick();
      check1("both_q", q_f[1], 1'b0);
      check1("both_qn", qn_f[1], 1'b0);
      s[1] = 1'b0; r[1] = 1'b0; tick();
      check1("race_q", q_f[1], 1'b1);
      check1("race_qn", qn_f[1], 1'b0);
      s[1] = 1'b1; r[1] = 1'b1; tick();
      r[1] = 1'b0; tick();
      check1("release_r_q", q_f[1], 1'b1);
      s[1] = 1'b1; r[1] = 1'b1; tick();
      s[1] = 1'b0; tick();
      check1("release_s_q", q_f[1], 1'b0);
      check1("release_s_qn", qn_f[1], 1'b1);
      r[1] = 1'b0; tick();

      // 4: priority of clear and reset over a falling edge on channel 2
      j[2] = 1'b1; clk[2] = 1'b1; tick(); tick();
      clr_n[2] = 1'b0; s[2] = 1'b1; clk[2] = 1'b0; tick();
      check1("clr_prio_q", q_f[2], 1'b0);
      check1("clr_prio_qn", qn_f[2], 1'b1);
      clr_n[2] = 1'b1; s[2] = 1'b0; tick();
      clk[2] = 1'b1; tick();
      r[2] = 1'b1; clk[2] = 1'b0; tick();
      check1("r_prio_q", q_f[2], 1'b0);
      r[2] = 1'b0; tick();
      check1("edge_not_replayed", q_f[2], 1'b0);
      tick();
      check1("edge_not_replayed2", q_f[2], 1'b0);
      j = '0;

      // 5: reset mid-operation with coincident edges
      clr_n = 4'h0; tick();
      clr_n = 4'hF; s = 4'hA; tick();
      s = 4'h0;
      check("pattern_a", q_f, 4'hA);
      j = 4'hF; k = 4'hF; clk = 4'hF; tick();
      check("pattern_a_rise", q_f, 4'hA);
      rst_n = 1'b0; clk = 4'h0; tick();
      check("midrst_q_f", q_f, 4'h0);
      check("midrst_qn_f", qn_f, 4'hF);
      check("midrst_q_r", q_r, 4'hF);
      check("midrst_qn_r", qn_r, 4'h0);
      rst_n = 1'b1; tick();
      check("post_rst_no_toggle_f", q_f, 4'h0);
      rst_n = 1'b0; clk = 4'hF; tick();
      rst_n = 1'b1; tick();
      check("post_rst_no_toggle_r", q_r, 4'hF);
      j = '0; k = '0;

      // 6: rising-edge bank, set then reset via JK on CLK[3]
      clr_n[3] = 1'b0; tick();
      clr_n[3] = 1'b1; clk[3] = 1'b0; tick();
      j[3] = 1'b1; tick();
      check1("rise_before_set", q_r[3], 1'b0);
      clk[3] = 1'b1; tick();
      check1("rise_set", q_r[3], 1'b1);
      j[3] = 1'b0; k[3] = 1'b1; tick();
      check1("rise_hold_high", q_r[3], 1'b1);
      clk[3] = 1'b0; tick();
      check1("rise_fall_ignored", q_r[3], 1'b1);
      clk[3] = 1'b1; tick();
      check1("rise_reset", q_r[3], 1'b0);
      k = '0;

      // randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         rst_n = ($urandom_range(0, 31) != 0);
         clk   = 4'($urandom);
         j     = 4'($urandom);
         k     = 4'($urandom);
         s     = 4'($urandom & $urandom & $urandom);
         r     = 4'($urandom & $urandom & $urandom);
         clr_n = ~4'($urandom & $urandom & $urandom);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
